// File: rtl/instr_stream_pkg.sv
// Shared types and constants for the instruction stream run controller.
package instr_stream_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReset,
    StRun,
    StDone
  } state_t;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;

  // Exactly one member is set once a run has finished.
  typedef struct packed {
    logic halted;
    logic timed_out;
    logic end_of_image;
  } status_t;

endpackage

// File: rtl/instr_stream_ctrl_image_store.sv
// Instruction image: DEPTH x XLEN register array, one write port, one combinational read port.
module image_store #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [XLEN-1:0]          rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  // No reset: the image survives rst so a run can be replayed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_stream_ctrl.sv
// Run controller: sequences core reset, streams the image over valid/ready, and ends the run
// on a halt word, end of image or timeout.
module instr_stream_ctrl
  import instr_stream_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     DEPTH      = 64,
  parameter int unsigned     RST_CYCLES = 2,
  parameter int unsigned     TIMEOUT    = 340,
  parameter logic [XLEN-1:0] HALT_WORD  = EBREAK,
  parameter bit              LOOP       = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [XLEN-1:0]          load_data,
  output logic                     core_rst,
  output logic [XLEN-1:0]          instr,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH)-1:0] pc_idx,
  output logic [31:0]              cycle_cnt,
  output logic                     done,
  output logic                     halted,
  output logic                     timed_out,
  output logic                     end_of_image
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned RCW = $clog2(RST_CYCLES + 1);

  state_t          state_q, state_d;
  logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            done_q, done_d;
  status_t         status_q, status_d;

  logic            store_we;
  logic [AW-1:0]   raddr;
  logic [XLEN-1:0] rdata;
  logic            ending;

  image_store #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_image_store (
    .clk   (clk),
    .we    (store_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    status_d  = status_q;
    raddr     = pc_q + AW'(1);
    store_we  = 1'b0;
    ending    = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        store_we = load_we;
        if (start) begin
          state_d   = StReset;
          rst_cnt_d = '0;
          cnt_d     = '0;
          pc_d      = '0;
          valid_d   = 1'b0;
          done_d    = 1'b0;
          status_d  = '0;
        end
      end

      StReset: begin
        if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
          state_d = StRun;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end

      StRun: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
        // valid is only low in RUN on the entry cycle: present word 0.
        if (!valid_q) begin
          raddr   = '0;
          instr_d = rdata;
          valid_d = 1'b1;
          pc_d    = '0;
        end else if (instr_ready) begin
          if (instr_q == HALT_WORD) begin
            status_d.halted = 1'b1;
            ending          = 1'b1;
          end else if (!LOOP && pc_q == AW'(DEPTH - 1)) begin
            status_d.end_of_image = 1'b1;
            ending                = 1'b1;
          end else begin
            instr_d = rdata;
            pc_d    = pc_q + AW'(1);
          end
        end
        // Timeout loses to a same-cycle halt or end of image.
        if (!ending && cnt_d >= TIMEOUT) begin
          status_d.timed_out = 1'b1;
          ending             = 1'b1;
        end
        if (ending) begin
          state_d = StDone;
          done_d  = 1'b1;
          valid_d = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rst_cnt_q <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      pc_q      <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      status_q  <= status_d;
    end
  end

  assign core_rst     = (state_q != StRun);
  assign instr        = instr_q;
  assign instr_valid  = valid_q;
  assign pc_idx       = pc_q;
  assign cycle_cnt    = cnt_q;
  assign done         = done_q;
  assign halted       = status_q.halted;
  assign timed_out    = status_q.timed_out;
  assign end_of_image = status_q.end_of_image;

endmodule

// File: tb/tb_instr_stream_ctrl.sv
// Directed bench for instr_stream_ctrl: three instances cover DEPTH=8 timeout/halt cases and
// DEPTH=4 end-of-image and loop-wrap behaviour.
module tb_instr_stream_ctrl;
  import instr_stream_pkg::*;

  localparam logic [31:0] ADDI1 = 32'h0010_0093;
  localparam logic [31:0] ADDI2 = 32'h0020_8113;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready = 1'b0;

  logic        start_a = 1'b0, we_a = 1'b0;
  logic [2:0]  la_a = '0;
  logic [31:0] ld_a = '0;
  logic        start_bc = 1'b0, we_bc = 1'b0;
  logic [1:0]  la_bc = '0;
  logic [31:0] ld_bc = '0;

  logic        a_core_rst, a_valid, a_done, a_halted, a_to, a_eoi;
  logic [31:0] a_instr, a_cnt;
  logic [2:0]  a_pc;
  logic        b_core_rst, b_valid, b_done, b_halted, b_to, b_eoi;
  logic [31:0] b_instr, b_cnt;
  logic [1:0]  b_pc;
  logic        c_core_rst, c_valid, c_done, c_halted, c_to, c_eoi;
  logic [31:0] c_instr, c_cnt;
  logic [1:0]  c_pc;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_stream_ctrl #(.XLEN(32), .DEPTH(8), .RST_CYCLES(2), .TIMEOUT(10),
                      .HALT_WORD(EBREAK), .LOOP(1'b0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .load_we(we_a), .load_addr(la_a),
    .load_data(ld_a), .core_rst(a_core_rst), .instr(a_instr), .instr_valid(a_valid),
    .instr_ready(ready), .pc_idx(a_pc), .cycle_cnt(a_cnt), .done(a_done),
    .halted(a_halted), .timed_out(a_to), .end_of_image(a_eoi)
  );

  instr_stream_ctrl #(.XLEN(32), .DEPTH(4), .RST_CYCLES(2), .TIMEOUT(10),
                      .HALT_WORD(EBREAK), .LOOP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_bc), .load_we(we_bc), .load_addr(la_bc),
    .load_data(ld_bc), .core_rst(b_core_rst), .instr(b_instr), .instr_valid(b_valid),
    .instr_ready(ready), .pc_idx(b_pc), .cycle_cnt(b_cnt), .done(b_done),
    .halted(b_halted), .timed_out(b_to), .end_of_image(b_eoi)
  );

  instr_stream_ctrl #(.XLEN(32), .DEPTH(4), .RST_CYCLES(2), .TIMEOUT(7),
                      .HALT_WORD(EBREAK), .LOOP(1'b1)) dut_c (
    .clk(clk), .rst(rst), .start(start_bc), .load_we(we_bc), .load_addr(la_bc),
    .load_data(ld_bc), .core_rst(c_core_rst), .instr(c_instr), .instr_valid(c_valid),
    .instr_ready(ready), .pc_idx(c_pc), .cycle_cnt(c_cnt), .done(c_done),
    .halted(c_halted), .timed_out(c_to), .end_of_image(c_eoi)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_a(input logic [2:0] a, input logic [31:0] d);
    we_a = 1'b1; la_a = a; ld_a = d;
    tick();
    we_a = 1'b0;
  endtask

  task automatic load_bc(input logic [1:0] a, input logic [31:0] d);
    we_bc = 1'b1; la_bc = a; ld_bc = d;
    tick();
    we_bc = 1'b0;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  // Expects image [ADDI1, ADDI2, EBREAK] and ready held high.
  task automatic run_basic_a(input string p);
    pulse_start_a();
    chk({p, ".rst0"}, a_core_rst, 1);
    chk({p, ".val0"}, a_valid, 0);
    chk({p, ".done_clr"}, a_done, 0);
    tick();
    chk({p, ".rst1"}, a_core_rst, 1);
    tick();
    chk({p, ".rst_low"}, a_core_rst, 0);
    chk({p, ".val_entry"}, a_valid, 0);
    tick();
    chk({p, ".val3"}, a_valid, 1);
    chk({p, ".w0"}, a_instr, ADDI1);
    chk({p, ".pc0"}, a_pc, 0);
    chk({p, ".cnt1"}, a_cnt, 1);
    tick();
    chk({p, ".w1"}, a_instr, ADDI2);
    chk({p, ".pc1"}, a_pc, 1);
    tick();
    chk({p, ".w2"}, a_instr, EBREAK);
    chk({p, ".pc2"}, a_pc, 2);
    tick();
    chk({p, ".done"}, a_done, 1);
    chk({p, ".halted"}, a_halted, 1);
    chk({p, ".to"}, a_to, 0);
    chk({p, ".eoi"}, a_eoi, 0);
    chk({p, ".val_end"}, a_valid, 0);
    chk({p, ".cnt"}, a_cnt, 4);
    chk({p, ".core_rst_end"}, a_core_rst, 1);
  endtask

  initial begin
    tick();
    tick();
    chk("rst.core_rst", a_core_rst, 1);
    chk("rst.instr", a_instr, 0);
    chk("rst.valid", a_valid, 0);
    chk("rst.pc", a_pc, 0);
    chk("rst.cnt", a_cnt, 0);
    chk("rst.flags", {a_done, a_halted, a_to, a_eoi}, 0);
    rst = 1'b0;

    // Basic three-word run ending on ebreak.
    load_a(3'd0, ADDI1);
    load_a(3'd1, ADDI2);
    load_a(3'd2, EBREAK);
    ready = 1'b1;
    run_basic_a("basic");

    // Stall word 1 for five cycles.
    pulse_start_a();
    chk("stall.done_clr", a_done, 0);
    chk("stall.halt_clr", a_halted, 0);
    tick();
    tick();
    tick();
    tick();
    chk("stall.pc1", a_pc, 1);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall.hold_instr", a_instr, ADDI2);
      chk("stall.hold_pc", a_pc, 1);
      chk("stall.hold_valid", a_valid, 1);
    end
    ready = 1'b1;
    tick();
    chk("stall.w2", a_instr, EBREAK);
    tick();
    chk("stall.halted", a_halted, 1);
    chk("stall.cnt", a_cnt, 9);

    // rst mid-run at cycle_cnt = 3, then replay from the retained image.
    pulse_start_a();
    tick();
    tick();
    tick();
    ready = 1'b0;
    tick();
    tick();
    chk("midrst.cnt3", a_cnt, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.core_rst", a_core_rst, 1);
    chk("midrst.instr", a_instr, 0);
    chk("midrst.valid", a_valid, 0);
    chk("midrst.pc", a_pc, 0);
    chk("midrst.cnt", a_cnt, 0);
    chk("midrst.flags", {a_done, a_halted, a_to, a_eoi}, 0);
    ready = 1'b1;
    run_basic_a("replay");

    // load_we in RESET and RUN, start in RUN: all ignored.
    pulse_start_a();
    we_a = 1'b1; la_a = 3'd1; ld_a = ECALL;
    tick();
    we_a = 1'b0;
    tick();
    tick();
    chk("ign.w0", a_instr, ADDI1);
    start_a = 1'b1; we_a = 1'b1; la_a = 3'd2; ld_a = ADDI1;
    tick();
    start_a = 1'b0; we_a = 1'b0;
    chk("ign.w1", a_instr, ADDI2);
    chk("ign.core_rst", a_core_rst, 0);
    chk("ign.cnt2", a_cnt, 2);
    tick();
    chk("ign.w2", a_instr, EBREAK);
    tick();
    chk("ign.halted", a_halted, 1);
    chk("ign.cnt", a_cnt, 4);

    // Halt on the last word on the same cycle as timeout.
    for (int i = 0; i < 7; i++) load_a(3'(i), ADDI1);
    load_a(3'd7, EBREAK);
    pulse_start_a();
    tick();
    tick();
    tick();
    ready = 1'b0;
    tick();
    ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("coin.pc7", a_pc, 7);
    chk("coin.cnt9", a_cnt, 9);
    tick();
    chk("coin.cnt", a_cnt, 10);
    chk("coin.halted", a_halted, 1);
    chk("coin.to", a_to, 0);
    chk("coin.eoi", a_eoi, 0);
    chk("coin.done", a_done, 1);

    // Timeout with ready held low.
    ready = 1'b0;
    pulse_start_a();
    tick();
    tick();
    tick();
    chk("to.cnt1", a_cnt, 1);
    for (int i = 0; i < 8; i++) tick();
    chk("to.cnt9", a_cnt, 9);
    chk("to.not_done", a_done, 0);
    tick();
    chk("to.cnt", a_cnt, 10);
    chk("to.flag", a_to, 1);
    chk("to.done", a_done, 1);
    chk("to.core_rst", a_core_rst, 1);
    chk("to.valid", a_valid, 0);
    chk("to.halted", a_halted, 0);
    tick();
    chk("to.frozen", a_cnt, 10);

    // DEPTH=4: end of image (LOOP=0) and pointer wrap then timeout (LOOP=1).
    for (int i = 0; i < 4; i++) load_bc(2'(i), ADDI1);
    ready = 1'b1;
    start_bc = 1'b1;
    tick();
    start_bc = 1'b0;
    tick();
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("loop.pc", c_pc, i % 4);
      chk("loop.valid", c_valid, 1);
      if (i < 4) chk("eoi.pc", b_pc, i);
      if (i == 4) begin
        chk("eoi.flag", b_eoi, 1);
        chk("eoi.done", b_done, 1);
        chk("eoi.halted", b_halted, 0);
        chk("eoi.to", b_to, 0);
        chk("eoi.valid", b_valid, 0);
        chk("eoi.cnt", b_cnt, 5);
      end
      tick();
    end
    chk("loop.to", c_to, 1);
    chk("loop.done", c_done, 1);
    chk("loop.valid_end", c_valid, 0);
    chk("loop.cnt", c_cnt, 7);
    chk("loop.eoi", c_eoi, 0);
    chk("loop.halted", c_halted, 0);
    chk("eoi.hold", b_eoi, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
